// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU between NREQ requesters.
// Each request runs IDLE (grant) -> EXEC (drive ALU) -> RESP (hold result until accepted).
module alu_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*4-1:0] req_op,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic [W-1:0]      alu_a,
    output logic [W-1:0]      alu_b,
    output logic [3:0]        alu_op,
    input  logic [W-1:0]      alu_res,
    output logic              busy
);
    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned OPW = 4;
    localparam int unsigned SHW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [IW-1:0]   rr_ptr, rr_ptr_d;
    logic [IW-1:0]   gnt, gnt_d;
    logic            illegal, illegal_d;
    logic [NREQ-1:0] rsp_valid_d;
    logic [W-1:0]    rsp_data_d;
    logic            rsp_err_d;
    logic [W-1:0]    alu_a_d, alu_b_d;
    logic [OPW-1:0]  alu_op_d;
    logic            busy_d;

    logic            found;
    logic [IW-1:0]   win;
    logic [IW:0]     idx;
    logic [W-1:0]    sel_a, sel_b;
    logic [OPW-1:0]  sel_op;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        case (op)
            4'b0000, 4'b1000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0101, 4'b1101, 4'b0110, 4'b0111, 4'b1001: op_legal = 1'b1;
            default:                                     op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic op_shift(input logic [OPW-1:0] op);
        op_shift = (op == 4'b0001) || (op == 4'b0101) || (op == 4'b1101);
    endfunction

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(i);
            if (idx >= (IW+1)'(NREQ)) begin
                idx = idx - (IW+1)'(NREQ);
            end
            if (!found && req_valid[idx[IW-1:0]]) begin
                found = 1'b1;
                win   = idx[IW-1:0];
            end
        end
    end

    // Operand mux for the winning requester
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (win == IW'(i)) begin
                sel_a  = req_a[i*W +: W];
                sel_b  = req_b[i*W +: W];
                sel_op = req_op[i*OPW +: OPW];
            end
        end
    end

    // Next-state and next-output logic; ALU ports fall back to zero outside EXEC
    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        gnt_d       = gnt;
        illegal_d   = illegal;
        req_ready   = '0;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        rsp_err_d   = rsp_err;
        alu_a_d     = '0;
        alu_b_d     = '0;
        alu_op_d    = '0;

        unique case (state)
            IDLE: begin
                if (found) begin
                    req_ready = NREQ'(1) << win;
                    gnt_d     = win;
                    illegal_d = !op_legal(sel_op);
                    if (op_legal(sel_op)) begin
                        alu_a_d  = sel_a;
                        alu_b_d  = op_shift(sel_op) ? W'(sel_b[SHW-1:0]) : sel_b;
                        alu_op_d = sel_op;
                    end
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_data_d  = illegal ? '0 : alu_res;
                rsp_err_d   = illegal;
                rsp_valid_d = NREQ'(1) << gnt;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready[gnt]) begin
                    rsp_valid_d = '0;
                    rr_ptr_d    = (gnt == IW'(NREQ - 1)) ? '0 : gnt + IW'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt       <= '0;
            illegal   <= 1'b0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            gnt       <= gnt_d;
            illegal   <= illegal_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            rsp_err   <= rsp_err_d;
            alu_a     <= alu_a_d;
            alu_b     <= alu_b_d;
            alu_op    <= alu_op_d;
            busy      <= busy_d;
        end
    end

endmodule
